// File: rtl/mul_acc_reduce.sv
// Sums COUNT consecutive valid products from the multiplier lane and drives the lane clock enable.
// Build option MUL_ACC_REDUCE_SAT_EN: saturate the narrowed sum instead of wrapping it.
module mul_acc_reduce #(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT       = 9,
    parameter int MUL_LATENCY = 4,
    parameter int FRAC_SHIFT  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_enable,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] prod,
    input  logic                    clear,
    output logic                    mul_ce,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic                    busy
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    // Result is {clipped, narrowed value}.
`ifdef MUL_ACC_REDUCE_SAT_EN
    function automatic logic [WIDTH:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-WIDTH:0] top;
        top = v[ACC_WIDTH-1:WIDTH-1];
        if (top == '0 || top == '1) return {1'b0, WIDTH'(v)};
        if (v[ACC_WIDTH-1])         return {2'b11, {(WIDTH-1){1'b0}}};
        return {2'b10, {(WIDTH-1){1'b1}}};
    endfunction
`else
    function automatic logic [WIDTH:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
        return {1'b0, WIDTH'(v)};
    endfunction
`endif

    logic [MUL_LATENCY-1:0]        vpipe;
    logic [CNT_W-1:0]              count;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_in;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   sum_shifted;
    logic [WIDTH:0]                narrowed;
    logic                          prod_valid;
    logic                          final_term;
    logic                          stall;

    assign stall       = out_valid && !out_ready;
    assign mul_ce      = clock_enable && !stall;
    assign prod_valid  = vpipe[MUL_LATENCY-1];
    assign final_term  = prod_valid && (count == CNT_W'(COUNT - 1));
    // A new sum starts from zero so the previous total never leaks into it.
    assign acc_in      = (count == '0) ? '0 : acc;
    assign sum         = acc_in + ACC_WIDTH'(prod);
    assign sum_shifted = sum >>> FRAC_SHIFT;
    assign narrowed    = narrow(sum_shifted);
    assign busy        = (count != '0) || (vpipe != '0);

    // Accumulation stage and output register; everything freezes with mul_ce.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpipe     <= '0;
            count     <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (mul_ce) begin
                if (clear) begin
                    vpipe <= '0;
                    count <= '0;
                    acc   <= '0;
                end else begin
                    vpipe <= (vpipe << 1) | MUL_LATENCY'(in_valid);
                    if (prod_valid) begin
                        acc   <= sum;
                        count <= final_term ? '0 : count + 1'b1;
                    end
                    if (final_term) begin
                        out_data <= narrowed[WIDTH-1:0];
                        out_sat  <= narrowed[WIDTH];
                    end
                end
            end
            // A new sum landing in the handshake cycle keeps out_valid high.
            if (mul_ce && !clear && final_term)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule
